// File: rtl/traffic_pkg.sv
// traffic_pkg: shared aspect/fault/state types and lamp bit positions for the light monitor.
package traffic_pkg;
    typedef enum logic [1:0] {ASP_RED, ASP_YEL, ASP_GRN, ASP_BAD} aspect_e;
    typedef enum logic [2:0] {FLT_NONE, FLT_CONFLICT, FLT_LAMP, FLT_SEQ, FLT_SHORT_Y, FLT_STUCK_Y} fault_e;
    typedef enum logic [1:0] {ARM, RUN, FAULT} mon_state_e;
    localparam int LAMP_G = 2;
    localparam int LAMP_Y = 1;
    localparam int LAMP_R = 0;
    localparam int ROAD_OFS = 3;

    function automatic aspect_e decode(input logic [2:0] l);
        return l == 3'(1 << LAMP_G) ? ASP_GRN :
               l == 3'(1 << LAMP_Y) ? ASP_YEL :
               l == 3'(1 << LAMP_R) ? ASP_RED : ASP_BAD;
    endfunction
endpackage

// File: rtl/aspect_tracker.sv
// aspect_tracker: per-road aspect decode, previous aspect and dwell counter with
// sequence and yellow-timing checks; arm_i takes the current sample as a fresh baseline.
module aspect_tracker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm_i,
    input  logic [2:0] lamps_i,
    output aspect_e    aspect_o,
    output logic       seq_err_o,
    output logic       short_y_o,
    output logic       stuck_y_o,
    output logic       rtg_o
);
    localparam int DW = $clog2(MAX_YELLOW + 2);

    aspect_e asp, prev_q, prev_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic chg, legal;

    always_comb begin
        asp = decode(lamps_i);
        chg = asp != prev_q;
        legal = (prev_q == ASP_GRN && asp == ASP_YEL) ||
                (prev_q == ASP_YEL && asp == ASP_RED) ||
                (prev_q == ASP_RED && asp == ASP_GRN);
        seq_err_o = !arm_i && chg && !legal;
        short_y_o = !arm_i && prev_q == ASP_YEL && asp == ASP_RED && dwell_q < DW'(MIN_YELLOW);
        // dwell_q excludes the current sample, so equality here means MAX_YELLOW+1 samples
        stuck_y_o = !arm_i && !chg && asp == ASP_YEL && dwell_q == DW'(MAX_YELLOW);
        rtg_o = !arm_i && prev_q == ASP_RED && asp == ASP_GRN;
        prev_d = asp;
        dwell_d = (arm_i || chg) ? DW'(1) : dwell_q + DW'(dwell_q != '1);
    end

    assign aspect_o = asp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= ASP_RED;
            dwell_q <= '0;
        end else begin
            prev_q <= prev_d;
            dwell_q <= dwell_d;
        end
    end
endmodule

// File: rtl/light_monitor.sv
// light_monitor: conflict/malfunction monitor on the light bus with a latched fault and
// flashing-red fallback. Define LIGHT_MON_STATS_EN to add per-road R->G counters.
module light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 8,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] light_i,
    input  logic       fault_clr_i,
    output logic [5:0] safe_light_o,
    output logic       fault_o,
    output logic [2:0] fault_code_o
`ifdef LIGHT_MON_STATS_EN
    ,
    output logic [15:0] hw_cycles_o,
    output logic [15:0] cr_cycles_o
`endif
);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam logic [5:0] ALL_RED = (6'(1) << (ROAD_OFS + LAMP_R)) | (6'(1) << LAMP_R);

    mon_state_e state_q;
    fault_e code_q, code_d;
    aspect_e hw_asp, cr_asp;
    logic [5:0] safe_q;
    logic [FW-1:0] flash_q, flash_d;
    logic fault_q, ph_q, ph_d, arm, conflict, lamp;
    logic hw_seq, hw_short, hw_stuck, hw_rtg, cr_seq, cr_short, cr_stuck, cr_rtg;

    assign arm = state_q == ARM;

    aspect_tracker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)) u_hw (
        .clk(clk), .rst(rst), .arm_i(arm), .lamps_i(light_i[2:0]), .aspect_o(hw_asp),
        .seq_err_o(hw_seq), .short_y_o(hw_short), .stuck_y_o(hw_stuck), .rtg_o(hw_rtg)
    );

    aspect_tracker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)) u_cr (
        .clk(clk), .rst(rst), .arm_i(arm), .lamps_i(light_i[ROAD_OFS +: 3]), .aspect_o(cr_asp),
        .seq_err_o(cr_seq), .short_y_o(cr_short), .stuck_y_o(cr_stuck), .rtg_o(cr_rtg)
    );

    always_comb begin
        conflict = (hw_asp == ASP_GRN || hw_asp == ASP_YEL) && (cr_asp == ASP_GRN || cr_asp == ASP_YEL);
        lamp = hw_asp == ASP_BAD || cr_asp == ASP_BAD;
        code_d = conflict ? FLT_CONFLICT :
                 lamp ? FLT_LAMP :
                 (hw_seq || cr_seq) ? FLT_SEQ :
                 (hw_stuck || cr_stuck) ? FLT_STUCK_Y :
                 (hw_short || cr_short) ? FLT_SHORT_Y : FLT_NONE;
        ph_d = flash_q == FW'(FLASH_HALF - 1) ? !ph_q : ph_q;
        flash_d = flash_q == FW'(FLASH_HALF - 1) ? '0 : flash_q + 1'b1;
    end

    // Offending sample is replaced by the flash pattern on the edge the fault is latched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARM;
            safe_q <= ALL_RED;
            fault_q <= 1'b0;
            code_q <= FLT_NONE;
            flash_q <= '0;
            ph_q <= 1'b1;
        end else if (state_q == FAULT) begin
            if (fault_clr_i) begin
                state_q <= ARM;
                safe_q <= ALL_RED;
                fault_q <= 1'b0;
                code_q <= FLT_NONE;
            end else begin
                flash_q <= flash_d;
                ph_q <= ph_d;
                safe_q <= ph_d ? ALL_RED : '0;
            end
        end else if (code_d != FLT_NONE) begin
            state_q <= FAULT;
            safe_q <= ALL_RED;
            fault_q <= 1'b1;
            code_q <= code_d;
            flash_q <= '0;
            ph_q <= 1'b1;
        end else begin
            state_q <= RUN;
            safe_q <= light_i;
        end
    end

    assign safe_light_o = safe_q;
    assign fault_o = fault_q;
    assign fault_code_o = code_q;

`ifdef LIGHT_MON_STATS_EN
    logic [15:0] hw_cnt_q, cr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hw_cnt_q <= '0;
            cr_cnt_q <= '0;
        end else begin
            hw_cnt_q <= hw_cnt_q + 16'(state_q == RUN && hw_rtg && hw_cnt_q != '1);
            cr_cnt_q <= cr_cnt_q + 16'(state_q == RUN && cr_rtg && cr_cnt_q != '1);
        end
    end

    assign hw_cycles_o = hw_cnt_q;
    assign cr_cycles_o = cr_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = hw_rtg ^ cr_rtg;
`endif
endmodule
